// File: rtl/link_pkg.sv
// Shared definitions for the 10-bit serial link (transmitter and receiver).
// Holds line levels, default payload/frame sizes and the frame state enum.
package link_pkg;

  // Line levels seen on the wire.
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Default payload width and resulting frame length.
  localparam int LINK_DATA_W = 8;
  localparam int FRAME_BITS  = LINK_DATA_W + 2;

  // Frame sequencer states, shared by both link ends.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } link_state_e;

endpackage

// File: rtl/bit_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on wrap.
// Ports: clk, reset (sync, active-high), en, clr (sync clear), tick (1-cycle).
module bit_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Tick on the last clock of a bit period.
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (tick) cnt_d = '0;
      else      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/shift_register_out.sv
// Parallel-in serial-out frame transmitter: start, data MSB first, stop.
// Ports: clk, reset (sync, active-high), ParData, Load -> SerOut, Busy, Done.
module shift_register_out
  import link_pkg::*;
#(
  parameter int DATA_W       = LINK_DATA_W,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] ParData,
  input  logic              Load,
  output logic              SerOut,
  output logic              Busy,
  output logic              Done
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  link_state_e       state_q, state_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              ser_q, ser_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tick;
  logic              in_idle;

  assign in_idle = (state_q == IDLE);

  // Timer runs only during a frame and restarts from 0 on each new one.
  bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .en   (!in_idle),
    .clr  (in_idle),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    bit_d   = bit_q;
    ser_d   = ser_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ser_d  = IDLE_LEVEL;
        busy_d = 1'b0;
        if (Load) begin
          state_d = START;
          sreg_d  = ParData;
          ser_d   = START_BIT;
          busy_d  = 1'b1;
        end
      end
      START: begin
        // Present D[MSB] and pre-shift so the next bit sits in the MSB.
        if (tick) begin
          state_d = DATA;
          ser_d   = sreg_q[DATA_W-1];
          sreg_d  = sreg_q << 1;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
            ser_d   = STOP_BIT;
            bit_d   = '0;
          end else begin
            ser_d  = sreg_q[DATA_W-1];
            sreg_d = sreg_q << 1;
            bit_d  = bit_q + BW'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          ser_d   = IDLE_LEVEL;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = IDLE_LEVEL;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      bit_q   <= '0;
      ser_q   <= IDLE_LEVEL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign SerOut = ser_q;
  assign Busy   = busy_q;
  assign Done   = done_q;

endmodule
